// File: rtl/seg_serial_capture_if.sv
// Serial display link (sck/rck/din) plus the decoded readback produced by the capture block.
interface seg_serial_capture_if;
  logic        seg_sck;
  logic        seg_rck;
  logic        seg_din;
  logic [31:0] dig_code;
  logic [7:0]  dig_known;
  logic [7:0]  dig_dot;
  logic        word_valid;
  logic [2:0]  word_digit;
  logic        frame_valid;
  logic        framing_err;
  logic        select_err;
  logic [7:0]  err_cnt;
  logic        link_alive;

  modport master (
    output seg_sck, seg_rck, seg_din,
    input  dig_code, dig_known, dig_dot, word_valid, word_digit,
           frame_valid, framing_err, select_err, err_cnt, link_alive
  );

  modport slave (
    input  seg_sck, seg_rck, seg_din,
    output dig_code, dig_known, dig_dot, word_valid, word_digit,
           frame_valid, framing_err, select_err, err_cnt, link_alive
  );
endinterface

// File: rtl/seg_serial_capture.sv
// Oversampling receiver for the 74HC595-style segment stream: deserialises 16-bit
// words and decodes digit select / segment pattern back into hex codes and dp flags.
module seg_serial_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input logic               clk,
  input logic               rst,
  seg_serial_capture_if.slave bus
);

  logic [2:0]                  w_pins;
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]                  r_in_q;
  logic [1:0]                  r_edge_d;

  logic        w_sck_rise;
  logic        w_rck_rise;
  logic [15:0] r_shreg;
  logic [15:0] w_shreg_next;
  logic [4:0]  r_bit_cnt;
  logic [4:0]  w_cnt_next;
  logic [7:0]  w_sel_n;
  logic        w_sel_ok;
  logic [2:0]  w_digit;
  logic [4:0]  w_hex;
  logic [7:0]  r_seen;
  logic [7:0]  w_seen_next;
  logic [23:0] r_timer;
  logic [23:0] w_timer_next;

  logic [31:0] r_dig_code;
  logic [7:0]  r_dig_known;
  logic [7:0]  r_dig_dot;
  logic        r_word_valid;
  logic [2:0]  r_word_digit;
  logic        r_frame_valid;
  logic        r_framing_err;
  logic        r_select_err;
  logic [7:0]  r_err_cnt;
  logic        r_link_alive;

  // Returns {hit, value} for an active-high g..a segment pattern.
  function automatic logic [4:0] hex_lookup(input logic [6:0] seg);
    case (seg)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  assign w_pins = {bus.seg_sck, bus.seg_rck, bus.seg_din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_in_q   <= '0;
      r_edge_d <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], w_pins};
      r_in_q   <= r_sync[SYNC_STAGES-1];
      r_edge_d <= r_in_q[2:1];
    end
  end

  // A coincident sck rise is folded in before the rck check, so that bit belongs to the word.
  always_comb begin
    w_sck_rise   = r_in_q[2] & ~r_edge_d[1];
    w_rck_rise   = r_in_q[1] & ~r_edge_d[0];
    w_shreg_next = w_sck_rise ? {r_shreg[14:0], r_in_q[0]} : r_shreg;
    w_cnt_next   = (w_sck_rise && (r_bit_cnt != 5'd17)) ? r_bit_cnt + 5'd1 : r_bit_cnt;
    w_sel_n      = ~w_shreg_next[15:8];
    w_sel_ok     = (w_sel_n != 8'd0) && ((w_sel_n & (w_sel_n - 8'd1)) == 8'd0);
    w_digit      = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (w_sel_n[k]) w_digit = 3'(k);
    end
    w_hex        = hex_lookup(~w_shreg_next[6:0]);
    w_seen_next  = r_seen | (8'd1 << w_digit);
    if (w_rck_rise)
      w_timer_next = '0;
    else if (r_timer == '1)
      w_timer_next = r_timer;
    else
      w_timer_next = r_timer + 24'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_seen        <= '0;
      r_timer       <= '0;
      r_dig_code    <= '0;
      r_dig_known   <= '0;
      r_dig_dot     <= '0;
      r_word_valid  <= 1'b0;
      r_word_digit  <= '0;
      r_frame_valid <= 1'b0;
      r_framing_err <= 1'b0;
      r_select_err  <= 1'b0;
      r_err_cnt     <= '0;
      r_link_alive  <= 1'b0;
    end else begin
      r_word_valid  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_framing_err <= 1'b0;
      r_select_err  <= 1'b0;
      r_shreg       <= w_shreg_next;
      r_bit_cnt     <= w_cnt_next;
      r_timer       <= w_timer_next;
      r_link_alive  <= (w_timer_next < TIMEOUT_CYC);

      if (w_rck_rise) begin
        r_bit_cnt <= '0;
        if (w_cnt_next != 5'd16) begin
          r_framing_err <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else if (!w_sel_ok) begin
          r_select_err <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
          r_dig_code[{w_digit, 2'b00} +: 4] <= w_hex[4] ? w_hex[3:0] : 4'h0;
          r_dig_known[w_digit]              <= w_hex[4];
          r_dig_dot[w_digit]                <= ~w_shreg_next[7];
          r_word_valid                      <= 1'b1;
          r_word_digit                      <= w_digit;
          if (w_seen_next == 8'hFF) begin
            r_frame_valid <= 1'b1;
            r_seen        <= '0;
          end else begin
            r_seen <= w_seen_next;
          end
        end
      end
    end
  end

  assign bus.dig_code    = r_dig_code;
  assign bus.dig_known   = r_dig_known;
  assign bus.dig_dot     = r_dig_dot;
  assign bus.word_valid  = r_word_valid;
  assign bus.word_digit  = r_word_digit;
  assign bus.frame_valid = r_frame_valid;
  assign bus.framing_err = r_framing_err;
  assign bus.select_err  = r_select_err;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.link_alive  = r_link_alive;

endmodule

// File: tb/tb_seg_serial_capture.sv
// Scoreboard bench for seg_serial_capture: directed words with hand-computed decode results.
module tb_seg_serial_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_serial_capture_if bus();

  seg_serial_capture #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(24'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         kind;   // 0 word, 1 framing error, 2 select error
    logic [2:0] digit;
    logic [31:0] code;
    logic [7:0] known;
    logic [7:0] dot;
    logic       frame;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int ev_idx = 0;

  always @(negedge clk) begin
    if (!rst && (bus.word_valid || bus.framing_err || bus.select_err || bus.frame_valid)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event wv=%0b fe=%0b se=%0b fv=%0b required=no_event",
                 bus.word_valid, bus.framing_err, bus.select_err, bus.frame_valid);
      end else begin
        e = q.pop_front();
        if (bus.word_valid !== (e.kind == 0) || bus.framing_err !== (e.kind == 1) ||
            bus.select_err !== (e.kind == 2) || bus.frame_valid !== e.frame ||
            bus.dig_code !== e.code || bus.dig_known !== e.known || bus.dig_dot !== e.dot ||
            bus.err_cnt !== e.err || (e.kind == 0 && bus.word_digit !== e.digit)) begin
          failures++;
          $display("FAIL event%0d got wv=%0b fe=%0b se=%0b fv=%0b dig=%0d code=%h known=%h dot=%h err=%0d required kind=%0d fv=%0b dig=%0d code=%h known=%h dot=%h err=%0d",
                   ev_idx, bus.word_valid, bus.framing_err, bus.select_err, bus.frame_valid,
                   bus.word_digit, bus.dig_code, bus.dig_known, bus.dig_dot, bus.err_cnt,
                   e.kind, e.frame, e.digit, e.code, e.known, e.dot, e.err);
        end
      end
      ev_idx++;
    end
  end

  task automatic expect_ev(input int kind, input logic [2:0] digit, input logic [31:0] code,
                           input logic [7:0] known, input logic [7:0] dot, input logic frame,
                           input logic [7:0] err);
    exp_t x;
    x.kind = kind; x.digit = digit; x.code = code; x.known = known;
    x.dot = dot; x.frame = frame; x.err = err;
    q.push_back(x);
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.dig_code, bus.dig_known, bus.dig_dot, bus.word_valid, bus.word_digit,
            bus.frame_valid, bus.framing_err, bus.select_err, bus.err_cnt, bus.link_alive};
  endfunction

  task automatic send_bit(input logic b);
    bus.seg_din = b;
    bus.seg_sck = 1'b0;
    repeat (2) @(negedge clk);
    bus.seg_sck = 1'b1;
    repeat (2) @(negedge clk);
    bus.seg_sck = 1'b0;
  endtask

  task automatic pulse_rck();
    repeat (2) @(negedge clk);
    bus.seg_rck = 1'b1;
    repeat (2) @(negedge clk);
    bus.seg_rck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) send_bit(w[i]);
    pulse_rck();
  endtask

  // Last sck rise lands in the same clk cycle as the rck rise.
  task automatic send_word_sim(input logic [15:0] w);
    for (int i = 15; i > 0; i--) send_bit(w[i]);
    bus.seg_din = w[0];
    bus.seg_sck = 1'b0;
    repeat (2) @(negedge clk);
    bus.seg_sck = 1'b1;
    bus.seg_rck = 1'b1;
    repeat (2) @(negedge clk);
    bus.seg_sck = 1'b0;
    bus.seg_rck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.seg_sck = 1'b0;
    bus.seg_rck = 1'b0;
    bus.seg_din = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Digit 0 showing "0", dp off
    expect_ev(0, 3'd0, 32'h0000_0000, 8'h01, 8'h00, 1'b0, 8'd0);
    send_word(16'hFEC0, 16);
    drain();
    check_val("link_alive_after_word", {63'd0, bus.link_alive}, 64'd1);

    // Digit 3 showing "5."
    expect_ev(0, 3'd3, 32'h0000_5000, 8'h09, 8'h08, 1'b0, 8'd0);
    send_word(16'hF712, 16);
    drain();

    // Frame 0..7 with a repeated digit 2; frame_valid only on digit 7
    expect_ev(0, 3'd0, 32'h0000_5000, 8'h09, 8'h08, 1'b0, 8'd0);
    send_word(16'hFEC0, 16);
    expect_ev(0, 3'd1, 32'h0000_5010, 8'h0B, 8'h08, 1'b0, 8'd0);
    send_word(16'hFDF9, 16);
    expect_ev(0, 3'd2, 32'h0000_5210, 8'h0F, 8'h08, 1'b0, 8'd0);
    send_word(16'hFBA4, 16);
    expect_ev(0, 3'd2, 32'h0000_5210, 8'h0F, 8'h08, 1'b0, 8'd0);
    send_word(16'hFBA4, 16);
    expect_ev(0, 3'd3, 32'h0000_3210, 8'h0F, 8'h00, 1'b0, 8'd0);
    send_word(16'hF7B0, 16);
    expect_ev(0, 3'd4, 32'h0004_3210, 8'h1F, 8'h00, 1'b0, 8'd0);
    send_word(16'hEF99, 16);
    expect_ev(0, 3'd5, 32'h0054_3210, 8'h3F, 8'h00, 1'b0, 8'd0);
    send_word(16'hDF92, 16);
    expect_ev(0, 3'd6, 32'h0654_3210, 8'h7F, 8'h00, 1'b0, 8'd0);
    send_word(16'hBF82, 16);
    expect_ev(0, 3'd7, 32'h7654_3210, 8'hFF, 8'h00, 1'b1, 8'd0);
    send_word(16'h7FF8, 16);
    drain();

    // Framing error: 15 bits
    expect_ev(1, 3'd0, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 8'd1);
    send_word(16'hFEC0, 15);
    drain();

    // Select error: two digits selected
    expect_ev(2, 3'd0, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 8'd2);
    send_word(16'hFCC0, 16);
    drain();

    // Blank pattern on digit 5
    expect_ev(0, 3'd5, 32'h7604_3210, 8'hDF, 8'h00, 1'b0, 8'd2);
    send_word(16'hDFFF, 16);
    drain();

    // Digit 1 showing "A." with the 16th sck rise coincident with rck
    expect_ev(0, 3'd1, 32'h7604_32A0, 8'hDF, 8'h02, 1'b0, 8'd2);
    send_word_sim(16'hFD08);
    drain();

    // Watchdog: no rck for well over 100 cycles, then a bare rck restores the link
    repeat (150) @(negedge clk);
    check_val("link_alive_timeout", {63'd0, bus.link_alive}, 64'd0);
    expect_ev(1, 3'd0, 32'h7604_32A0, 8'hDF, 8'h02, 1'b0, 8'd3);
    pulse_rck();
    repeat (4) @(negedge clk);
    check_val("link_alive_restored", {63'd0, bus.link_alive}, 64'd1);
    drain();

    // Reset after 8 bits clears all outputs asynchronously
    for (int i = 15; i > 7; i--) send_bit(1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_val("async_reset_outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    expect_ev(1, 3'd0, 32'h0000_0000, 8'h00, 8'h00, 1'b0, 8'd1);
    send_word(16'hFEC0, 8);
    drain();
    expect_ev(0, 3'd0, 32'h0000_0000, 8'h01, 8'h00, 1'b0, 8'd1);
    send_word(16'hFEC0, 16);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_serial_capture.md
# seg_serial_capture

Receive-side decoder for the 74HC595-style serial stream (seg_sck / seg_rck / seg_din) that the 8-digit segment scan driver emits. It oversamples the three lines in the system clock domain and deserialises each 16-bit word. It decodes the digit select and the segment pattern back into per-digit hex codes and decimal-point flags, and reports framing and select errors. It serves as an on-chip readback monitor for the display path and as a self-check block in display-path testbenches.

## Interface
- SYNC_STAGES, 2: synchroniser depth on seg_sck, seg_rck and seg_din (minimum 2).
- TIMEOUT_CYC, 24'd5_000_000: number of clk cycles without a seg_rck rise before link_alive drops.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_sck  in  1  shift clock; data is sampled on its rising edge.
- seg_rck  in  1  latch clock; its rising edge ends the word.
- seg_din  in  1  serial data, MSB first.
- dig_code  out  32  nibble k (bits 4k+3:4k) is the decoded hex value of digit k.
- dig_known  out  8  bit k high means digit k holds a pattern found in the hex table.
- dig_dot  out  8  bit k is the decimal point state of digit k.
- word_valid  out  1  one-cycle pulse when a good word has been stored.
- word_digit  out  3  index of the last stored digit; updated together with word_valid.
- frame_valid  out  1  one-cycle pulse when all 8 digits have been refreshed since the previous pulse.
- framing_err  out  1  one-cycle pulse when seg_rck rises with a bit count other than 16.
- select_err  out  1  one-cycle pulse when a 16-bit word has an illegal select field.
- err_cnt  out  8  saturating count of framing and select errors.
- link_alive  out  1  high while seg_rck rises are arriving.

## Operation
- **Input conditioning:** each input passes through a SYNC_STAGES flop chain, then one more register. A rise is (registered & ~previous).
- **Shift on sck rise:** shreg <= {shreg[14:0], din_sync}. bit_cnt (5 bits) increments and saturates at 17.
- **Word format:**
  - shreg[15:8] is the digit select, active-low one-hot; bit 8+k low selects digit k.
  - shreg[7] is the dp, active-low.
  - shreg[6:0] are segments g..a, active-low.
- **On rck rise, bit_cnt ≠ 16:** framing_err pulses and the word is discarded.
- **On rck rise, bit_cnt == 16, select not exactly one zero:** select_err pulses and the word is discarded.
- **On rck rise, bit_cnt == 16, select legal:**
  - Invert the segments to active-high and look them up in the hex table.
  - Table (active-high pattern to value): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Hit: dig_code[k] = value, dig_known[k] = 1.
  - Miss (including blank 00): dig_code[k] = 0, dig_known[k] = 0.
  - dig_dot[k] = ~shreg[7].
  - word_valid pulses; word_digit = k.
- **Every rck rise:** bit_cnt clears to 0, whatever the outcome.
- **Frame tracking:**
  - Each stored word sets seen[k].
  - When seen becomes 8'hFF, frame_valid pulses in the same cycle as that word's word_valid, and seen clears.
  - Repeated digits before completion are allowed.
  - Errors do not clear seen.
- **err_cnt:** +1 per framing_err or select_err, saturating at 255. Both errors cannot occur on the same word.
- **Watchdog:** a timer clears on every rck rise and otherwise increments, saturating. link_alive = (timer < TIMEOUT_CYC).

## Timing
- **Reset values:** all outputs 0, including link_alive. Internal state is also 0: shreg, bit_cnt, seen, timer, synchronisers.
- **Reset mid-word:** the partial word is lost. The first rck rise after release with fewer than 16 bits gives framing_err.
- **Latency:** a pin edge is seen as a rise SYNC_STAGES+1 clk cycles later. word_valid, framing_err and select_err are registered one cycle after the rck rise is detected. Pin-to-pulse latency is therefore SYNC_STAGES+2 cycles.
- **sck and rck rise in the same cycle:** the shift and count happen first, and the rck check uses the updated shreg and bit_cnt. The bit is part of the word.
- **Pulse width:** word_valid, frame_valid and the error pulses are exactly 1 cycle each. Outputs hold between updates.
- **Input rates:** inputs must hold each level for at least 2 clk cycles. Faster toggling is out of scope.

## Test plan
- **Good word, digit 0:** 16 sck pulses of 0xFEC0, then rck. Expect word_valid, word_digit=0, dig_code[3:0]=0, dig_known[0]=1, dig_dot[0]=0.
- **Digit 3, "5.":** word 0xF712. Expect dig_code[15:12]=5, dig_known[3]=1, dig_dot[3]=1.
- **Full frame:** digits 0..7 showing 0..7. Expect frame_valid on the 8th word only and dig_code=32'h76543210; a repeated digit 2 mid-frame must not fire frame_valid early.
- **Errors:**
  - 15 bits then rck: framing_err, err_cnt=1.
  - Word 0xFCC0 (two selects): select_err, err_cnt=2.
  - In both cases dig_* is unchanged.
- **Unknown pattern and simultaneous edge:**
  - Segment byte 0xFF (blank): dig_known[k]=0, dig_code=0.
  - The 16th sck rise coincident with rck is still accepted.
- **Watchdog and reset:**
  - With TIMEOUT_CYC=100 and no rck for 100 cycles, link_alive falls; the next rck restores it.
  - rst asserted after 8 bits clears all outputs immediately.
